song_sequencer: RTL and testbench
=================================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 Parameter NOTE_W, default 6, note code width.
REQ-002 Parameter DUR_W, default 6, duration width in 1/48 s beats.
REQ-003 Parameter SONG_W, default 2, song select width (4 songs).
REQ-004 Parameter IDX_W, default 5, note index width (32 entries per song).
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 play  in  1  level; high = run, low = pause.
REQ-008 next_song  in  1  one-cycle pulse; advance to next song.
REQ-009 rom_addr  out  SONG_W+IDX_W  {song, index} to song ROM.
REQ-010 rom_data  in  NOTE_W+DUR_W  {note, duration}; valid exactly 1 cycle after rom_addr.
REQ-011 done_with_note  in  1  from note player; note duration expired.
REQ-012 note_to_load  out  NOTE_W  note code to note player.
REQ-013 duration_to_load  out  DUR_W  duration to note player.
REQ-014 load_new_note  out  1  one-cycle load strobe to note player.
REQ-015 play_enable  out  1  enable to note player.
REQ-016 song_done  out  1  one-cycle pulse at end of song.
REQ-017 current_song  out  SONG_W  song being played.

Function
REQ-018 States SHALL be IDLE, FETCH, WAIT_ROM, LOAD, WAIT_NOTE, END.
REQ-019 IDLE: play high -> FETCH; otherwise remain.
REQ-020 FETCH: rom_addr = {song, index}; next state WAIT_ROM.
REQ-021 WAIT_ROM: register rom_data; duration == 0 or index == all-ones past last valid entry -> END, else LOAD.
REQ-022 LOAD: load_new_note = 1 for exactly this cycle; note_to_load/duration_to_load hold registered entry from this cycle until the next LOAD; next state WAIT_NOTE.
REQ-023 WAIT_NOTE: done_with_note sampled only here; when high, index increments and state -> FETCH.
REQ-024 Increment from index 31 SHALL wrap the song: state -> END instead of FETCH; index -> 0.
REQ-025 END: song_done = 1 for the entry cycle only; play_enable low; remain until next_song, or play low (-> IDLE, index 0).
REQ-026 play_enable = play AND state in {FETCH, WAIT_ROM, LOAD, WAIT_NOTE}.
REQ-027 play low in any non-IDLE state other than END -> IDLE; index retained, so the current note restarts from its start on resume.
REQ-028 next_song in any state: song <= song+1 modulo 2^SONG_W, index <= 0, state -> FETCH if play else IDLE.
REQ-029 next_song has priority over done_with_note, end detection and play changes in the same cycle; the song_done pulse is suppressed in that cycle.
REQ-030 Latency from done_with_note to load_new_note SHALL be exactly 3 cycles (FETCH, WAIT_ROM, LOAD).
REQ-031 rom_addr is registered; it changes only on FETCH entry, next_song or reset.

Reset
REQ-032 Reset SHALL force state IDLE, song 0, index 0, and all outputs 0 (rom_addr 0, note/duration 0, strobes low, play_enable low, current_song 0).
REQ-033 Reset mid-note SHALL drop play_enable the following cycle; no load_new_note issues until play is sampled high after reset release.

Structure
REQ-034 A shared package SHALL hold NOTE_W, DUR_W, SONG_W, IDX_W, the state encoding and the END_MARKER duration value (0).
REQ-035 The block is a single module; the song ROM is external and is addressed through rom_addr/rom_data.

Verification
REQ-036 ROM song0 = {(12,4),(20,2),(x,0)}; play=1 -> loads of 12/4 and 20/2, one song_done after the second done_with_note, then END.
REQ-037 done_with_note at cycle N in WAIT_NOTE -> load_new_note at N+3; note_to_load is stable between loads.
REQ-038 play dropped mid-note at index 5, raised 10 cycles later -> play_enable low during the pause; FETCH again with rom_addr index 5.
REQ-039 next_song and done_with_note in the same cycle, song 3 -> current_song 0, index 0, no song_done, first load from rom_addr 0.
REQ-040 Song 1 with 32 nonzero entries -> after the 32nd done_with_note: song_done pulse, index 0, state END.
REQ-041 reset asserted in WAIT_NOTE -> all outputs 0 the next cycle; no load until play is high after release.

Source files
------------

// File: rtl/song_sequencer_pkg.sv
// Shared constants for the song sequencer: default field widths, the
// controller state encoding and the duration value that marks end-of-song.
package song_sequencer_pkg;

  localparam int NOTE_W  = 6;  // note code width
  localparam int DUR_W   = 6;  // duration width, in 1/48 s beats
  localparam int SONG_W  = 2;  // song select width (4 songs)
  localparam int IDX_W   = 5;  // note index width (32 entries per song)
  localparam int STATE_W = 3;

  // Controller states. Plain constants keep the encoding stable for older
  // blocks and checkers that decode the debug state bus.
  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0,
                                 S_FETCH     = 3'd1,
                                 S_WAIT_ROM  = 3'd2,
                                 S_LOAD      = 3'd3,
                                 S_WAIT_NOTE = 3'd4,
                                 S_END       = 3'd5;

  // A ROM entry whose duration equals this value terminates the song.
  localparam int END_MARKER = 0;

  // States in which the note player is allowed to run.
  function automatic logic state_is_active(input logic [STATE_W-1:0] s);
    return (s == S_FETCH) || (s == S_WAIT_ROM) || (s == S_LOAD) || (s == S_WAIT_NOTE);
  endfunction

endpackage

// File: rtl/song_sequencer.sv
// Song sequencer: walks the {note, duration} entries of the selected song in
// an external ROM and hands each one to the note player, one at a time.
//
// ROM handshake: rom_addr is registered and updated when FETCH is entered;
// the ROM returns the entry on rom_data one cycle later (during WAIT_ROM),
// where it is captured. The note player sees one load_new_note strobe per
// entry and answers with a single done_with_note pulse, which is only
// honoured in WAIT_NOTE. There is no back-pressure in either direction.
//
// Priority every cycle: reset, then next_song, then play low, then the
// per-state behaviour (done_with_note, end-of-song detection).
module song_sequencer #(
  parameter int NOTE_W = song_sequencer_pkg::NOTE_W,
  parameter int DUR_W  = song_sequencer_pkg::DUR_W,
  parameter int SONG_W = song_sequencer_pkg::SONG_W,
  parameter int IDX_W  = song_sequencer_pkg::IDX_W
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   play,
  input  logic                                   next_song,
  output logic [SONG_W+IDX_W-1:0]                rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]                rom_data,
  input  logic                                   done_with_note,
  output logic [NOTE_W-1:0]                      note_to_load,
  output logic [DUR_W-1:0]                       duration_to_load,
  output logic                                   load_new_note,
  output logic                                   play_enable,
  output logic                                   song_done,
  output logic [SONG_W-1:0]                      current_song,
  output logic [song_sequencer_pkg::STATE_W-1:0] debug_state
);

  import song_sequencer_pkg::*;

  logic [STATE_W-1:0] state;
  logic [SONG_W-1:0]  song;
  logic [IDX_W-1:0]   index;

  logic [SONG_W-1:0]  song_inc;
  logic [IDX_W-1:0]   index_inc;
  logic [NOTE_W-1:0]  rom_note;
  logic [DUR_W-1:0]   rom_dur;
  logic               rom_is_end;
  logic               index_is_last;

  // Helper terms: incremented counters and fields of the returned ROM entry.
  always_comb begin
    song_inc      = song + SONG_W'(1);
    index_inc     = index + IDX_W'(1);
    rom_note      = rom_data[NOTE_W+DUR_W-1:DUR_W];
    rom_dur       = rom_data[DUR_W-1:0];
    rom_is_end    = (rom_dur == DUR_W'(END_MARKER));
    index_is_last = (index == {IDX_W{1'b1}});
  end

  // Controller: song/index bookkeeping, ROM addressing and entry capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      song             <= '0;
      index            <= '0;
      rom_addr         <= '0;
      note_to_load     <= '0;
      duration_to_load <= '0;
      song_done        <= 1'b0;
    end else begin
      song_done <= 1'b0;
      if (next_song) begin
        // Song change wins over everything else and never reports song_done.
        song     <= song_inc;
        index    <= '0;
        rom_addr <= {song_inc, {IDX_W{1'b0}}};
        state    <= play ? S_FETCH : S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (play) begin
              state    <= S_FETCH;
              rom_addr <= {song, index};
            end
          end
          S_FETCH: begin
            state <= play ? S_WAIT_ROM : S_IDLE;
          end
          S_WAIT_ROM: begin
            if (!play) begin
              state <= S_IDLE;
            end else if (rom_is_end) begin
              state     <= S_END;
              song_done <= 1'b1;
            end else begin
              state            <= S_LOAD;
              note_to_load     <= rom_note;
              duration_to_load <= rom_dur;
            end
          end
          S_LOAD: begin
            state <= play ? S_WAIT_NOTE : S_IDLE;
          end
          S_WAIT_NOTE: begin
            // Pausing keeps the index, so the interrupted note restarts on resume.
            if (!play) begin
              state <= S_IDLE;
            end else if (done_with_note) begin
              if (index_is_last) begin
                // Past entry 31 the song wraps: finish instead of fetching.
                state     <= S_END;
                index     <= '0;
                song_done <= 1'b1;
              end else begin
                state    <= S_FETCH;
                index    <= index_inc;
                rom_addr <= {song, index_inc};
              end
            end
          end
          S_END: begin
            if (!play) begin
              state <= S_IDLE;
              index <= '0;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Strobes and enables decoded from the current state.
  always_comb begin
    load_new_note = (state == S_LOAD);
    play_enable   = play && state_is_active(state);
  end

  assign current_song = song;
  assign debug_state  = state;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer. A behavioural ROM and note player
// surround the DUT; the expected note stream is derived from the ROM image
// (entries of a song up to its end marker or entry 31) and checked by a
// scoreboard, while each scenario task checks its own control behaviour.
module tb_song_sequencer;

  import song_sequencer_pkg::*;

  localparam int NW = 6;
  localparam int DW = 6;
  localparam int SW = 2;
  localparam int IW = 5;
  localparam int EW = NW + DW;

  logic          clk;
  logic          reset;
  logic          play;
  logic          next_song;
  logic [SW+IW-1:0] rom_addr;
  logic [EW-1:0] rom_data;
  logic          done_with_note;
  logic [NW-1:0] note_to_load;
  logic [DW-1:0] duration_to_load;
  logic          load_new_note;
  logic          play_enable;
  logic          song_done;
  logic [SW-1:0] current_song;
  logic [STATE_W-1:0] debug_state;

  song_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .next_song        (next_song),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .done_with_note   (done_with_note),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .play_enable      (play_enable),
    .song_done        (song_done),
    .current_song     (current_song),
    .debug_state      (debug_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- song ROM model (1-cycle read latency) ----------------
  logic [EW-1:0] rom_mem [0:127];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  int load_count    = 0;
  int done_pulses   = 0;
  int dones_given   = 0;
  int last_done_cyc = -1;
  int cd            = 0;
  logic player_en   = 1'b0;
  int d_resume      = 0;
  int dp_ref        = 0;

  // ---------------- scoreboard (samples on falling edge) ----------------
  initial begin : scoreboard
    logic [EW-1:0] held;
    logic [EW-1:0] got;
    logic [EW-1:0] expv;
    logic held_valid;
    held_valid = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_valid = 1'b0;
      end else begin
        if (!held_valid) begin
          held = '0;
          held_valid = 1'b1;
        end
        got = {note_to_load, duration_to_load};
        if (load_new_note) begin
          load_count++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_load: got note/dur %0h, expected no load", got);
          end else begin
            expv = exp_q.pop_front();
            if (got !== expv) begin
              n_fail++;
              $display("FAIL load_value: got note/dur %0h expected %0h", got, expv);
            end
          end
          if (last_done_cyc >= 0) begin
            n_checks++;
            if (cyc - last_done_cyc != 3) begin
              n_fail++;
              $display("FAIL load_latency: got %0d cycles expected 3", cyc - last_done_cyc);
            end
            last_done_cyc = -1;
          end
          held = got;
        end else begin
          n_checks++;
          if (got !== held) begin
            n_fail++;
            $display("FAIL note_stable: got note/dur %0h expected %0h", got, held);
          end
        end
        if (song_done) done_pulses++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle; inputs change just after the rising edge. Also plays the note
  // player: after each load, wait a random 1..5 cycles, then pulse done.
  task automatic step();
    @(posedge clk);
    #1;
    done_with_note = 1'b0;
    if (player_en) begin
      if (load_new_note) begin
        cd = $urandom_range(1, 5);
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          done_with_note = 1'b1;
          last_done_cyc = cyc;
          dones_given++;
        end
      end
    end
  endtask

  task automatic run_until_done(input int budget);
    int d0;
    d0 = done_pulses;
    for (int t = 0; t < budget && done_pulses == d0; t++) step();
  endtask

  task automatic run_until_load(input int target, input int budget);
    for (int t = 0; t < budget && load_count < target; t++) step();
  endtask

  // Reference model: the notes a song yields from a start index onward.
  task automatic expect_song(input int s, input int start, output int n);
    logic [EW-1:0] e;
    n = 0;
    for (int i = start; i < 32; i++) begin
      e = rom_mem[s * 32 + i];
      if (e[DW-1:0] == '0) break;
      exp_q.push_back(e);
      n++;
    end
  endtask

  task automatic fill_rom();
    int len;
    for (int a = 0; a < 128; a++) rom_mem[a] = EW'($urandom);
    rom_mem[0] = {6'd12, 6'd4};
    rom_mem[1] = {6'd20, 6'd2};
    rom_mem[2] = {NW'($urandom), 6'd0};
    for (int i = 0; i < 32; i++) rom_mem[32 + i] = {NW'($urandom), DW'($urandom_range(1, 63))};
    len = $urandom_range(3, 31);
    for (int i = 0; i < len; i++) rom_mem[64 + i] = {NW'($urandom), DW'($urandom_range(1, 63))};
    rom_mem[64 + len] = {NW'($urandom), 6'd0};
    len = $urandom_range(4, 31);
    for (int i = 0; i < len; i++) rom_mem[96 + i] = {NW'($urandom), DW'($urandom_range(1, 63))};
    rom_mem[96 + len] = {NW'($urandom), 6'd0};
  endtask

  // Starts the next song from END with play high and checks the selection.
  task automatic start_next_song(input int s);
    int n;
    exp_q.delete();
    expect_song(s, 0, n);
    last_done_cyc = -1;
    player_en = 1'b1;
    next_song = 1'b1;
    step();
    next_song = 1'b0;
    n_checks++;
    if (current_song !== SW'(s) || debug_state !== S_FETCH) begin
      n_fail++;
      $display("FAIL next_song_select: got song %0d state %0d expected song %0d state %0d",
               current_song, debug_state, s, S_FETCH);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; play = 1'b1; next_song = 1'b0; done_with_note = 1'b0;
    player_en = 1'b0; cd = 0;
    repeat (3) step();
    n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_rom_addr: got %0h expected 0", rom_addr); end
    n_checks++; if (note_to_load !== '0) begin n_fail++; $display("FAIL reset_note: got %0h expected 0", note_to_load); end
    n_checks++; if (duration_to_load !== '0) begin n_fail++; $display("FAIL reset_duration: got %0h expected 0", duration_to_load); end
    n_checks++; if (load_new_note !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b expected 0", load_new_note); end
    n_checks++; if (play_enable !== 1'b0) begin n_fail++; $display("FAIL reset_play_enable: got %b expected 0", play_enable); end
    n_checks++; if (song_done !== 1'b0) begin n_fail++; $display("FAIL reset_song_done: got %b expected 0", song_done); end
    n_checks++; if (current_song !== '0) begin n_fail++; $display("FAIL reset_song: got %0d expected 0", current_song); end
    n_checks++; if (debug_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", debug_state, S_IDLE); end
    reset = 1'b0; play = 1'b0;
    repeat (3) step();
    n_checks++;
    if (debug_state !== S_IDLE || play_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got state %0d play_enable %b expected %0d 0", debug_state, play_enable, S_IDLE);
    end
  endtask

  task automatic test_short_song();
    int n, dp0, dg0;
    exp_q.delete();
    expect_song(0, 0, n);
    dp0 = done_pulses; dg0 = dones_given;
    last_done_cyc = -1; player_en = 1'b1; play = 1'b1;
    run_until_done(200);
    n_checks++; if (done_pulses != dp0 + 1) begin n_fail++; $display("FAIL short_song_done: got %0d pulses expected 1", done_pulses - dp0); end
    n_checks++; if (dones_given - dg0 != 2) begin n_fail++; $display("FAIL short_song_done_after: got %0d dones expected 2", dones_given - dg0); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL short_song_loads: got %0d missing expected 0", exp_q.size()); end
    repeat (3) step();
    n_checks++;
    if (debug_state !== S_END || play_enable !== 1'b0 || done_pulses != dp0 + 1) begin
      n_fail++;
      $display("FAIL short_song_end: got state %0d play_enable %b pulses %0d expected %0d 0 1",
               debug_state, play_enable, done_pulses - dp0, S_END);
    end
  endtask

  task automatic test_pause();
    int n, lc0;
    lc0 = load_count;
    start_next_song(1);
    run_until_load(lc0 + 6, 120);
    n_checks++; if (load_count != lc0 + 6) begin n_fail++; $display("FAIL pause_reach_idx5: got %0d loads expected 6", load_count - lc0); end
    step();
    player_en = 1'b0; cd = 0; done_with_note = 1'b0; play = 1'b0;
    #1;
    n_checks++; if (play_enable !== 1'b0) begin n_fail++; $display("FAIL pause_enable_drop: got %b expected 0", play_enable); end
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (play_enable !== 1'b0 || debug_state !== S_IDLE) begin
        n_fail++;
        $display("FAIL pause_hold: got play_enable %b state %0d expected 0 %0d", play_enable, debug_state, S_IDLE);
      end
    end
    exp_q.delete();
    expect_song(1, 5, n);
    last_done_cyc = -1; d_resume = dones_given; dp_ref = done_pulses;
    play = 1'b1; player_en = 1'b1;
    step();
    n_checks++;
    if (debug_state !== S_FETCH || rom_addr !== 7'd37) begin
      n_fail++;
      $display("FAIL pause_resume: got state %0d rom_addr %0h expected %0d 25", debug_state, rom_addr, S_FETCH);
    end
  endtask

  task automatic test_full_song();
    run_until_done(600);
    n_checks++; if (done_pulses != dp_ref + 1) begin n_fail++; $display("FAIL full_song_done: got %0d pulses expected 1", done_pulses - dp_ref); end
    n_checks++; if (dones_given - d_resume != 27) begin n_fail++; $display("FAIL full_song_wrap: got %0d dones expected 27", dones_given - d_resume); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_song_loads: got %0d missing expected 0", exp_q.size()); end
    step();
    n_checks++;
    if (debug_state !== S_END || song_done !== 1'b0 || play_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL full_song_end: got state %0d song_done %b play_enable %b expected %0d 0 0",
               debug_state, song_done, play_enable, S_END);
    end
  endtask

  task automatic test_random_song();
    int n, dp0, dg0;
    dp0 = done_pulses; dg0 = dones_given;
    start_next_song(2);
    n = exp_q.size();
    run_until_done(600);
    n_checks++; if (done_pulses != dp0 + 1) begin n_fail++; $display("FAIL random_song_done: got %0d pulses expected 1", done_pulses - dp0); end
    n_checks++; if (dones_given - dg0 != n) begin n_fail++; $display("FAIL random_song_len: got %0d dones expected %0d", dones_given - dg0, n); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL random_song_loads: got %0d missing expected 0", exp_q.size()); end
  endtask

  task automatic test_next_song_collision();
    int n, lc0, dp0;
    lc0 = load_count;
    start_next_song(3);
    run_until_load(lc0 + 2, 60);
    n_checks++; if (load_count != lc0 + 2) begin n_fail++; $display("FAIL collide_setup: got %0d loads expected 2", load_count - lc0); end
    step();
    player_en = 1'b0; cd = 0;
    dp0 = done_pulses;
    done_with_note = 1'b1; next_song = 1'b1;
    step();
    next_song = 1'b0;
    n_checks++;
    if (current_song !== '0 || rom_addr !== '0 || debug_state !== S_FETCH || song_done !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_switch: got song %0d rom_addr %0h state %0d song_done %b expected 0 0 %0d 0",
               current_song, rom_addr, debug_state, song_done, S_FETCH);
    end
    exp_q.delete();
    expect_song(0, 0, n);
    last_done_cyc = -1; player_en = 1'b1;
    lc0 = load_count;
    run_until_load(lc0 + 1, 10);
    n_checks++; if (load_count != lc0 + 1) begin n_fail++; $display("FAIL collide_first_load: got %0d loads expected 1", load_count - lc0); end
    n_checks++; if (done_pulses != dp0) begin n_fail++; $display("FAIL collide_no_done: got %0d pulses expected 0", done_pulses - dp0); end
    run_until_done(200);
    n_checks++; if (done_pulses != dp0 + 1 || exp_q.size() != 0) begin n_fail++; $display("FAIL collide_song0: got %0d pulses %0d missing expected 1 0", done_pulses - dp0, exp_q.size()); end
  endtask

  task automatic test_reset_mid_note();
    int n, lc0;
    lc0 = load_count;
    start_next_song(1);
    run_until_load(lc0 + 1, 20);
    step();
    player_en = 1'b0; cd = 0;
    reset = 1'b1;
    step();
    n_checks++;
    if (rom_addr !== '0 || note_to_load !== '0 || duration_to_load !== '0 || load_new_note !== 1'b0 ||
        play_enable !== 1'b0 || song_done !== 1'b0 || current_song !== '0 || debug_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_note: got addr %0h note %0h dur %0h load %b en %b done %b song %0d state %0d expected all 0",
               rom_addr, note_to_load, duration_to_load, load_new_note, play_enable, song_done, current_song, debug_state);
    end
    reset = 1'b0; play = 1'b0;
    exp_q.delete();
    lc0 = load_count;
    repeat (5) step();
    n_checks++;
    if (load_count != lc0 || debug_state !== S_IDLE || play_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_load: got %0d loads state %0d en %b expected 0 %0d 0", load_count - lc0, debug_state, play_enable, S_IDLE);
    end
    expect_song(0, 0, n);
    last_done_cyc = -1; play = 1'b1; player_en = 1'b1;
    run_until_load(lc0 + 1, 10);
    n_checks++; if (load_count != lc0 + 1) begin n_fail++; $display("FAIL reset_resume_load: got %0d loads expected 1", load_count - lc0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; play = 1'b0; next_song = 1'b0; done_with_note = 1'b0;
    fill_rom();
    test_reset();
    test_short_song();
    test_pause();
    test_full_song();
    test_random_song();
    test_next_song_collision();
    test_reset_mid_note();
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
